// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the mult/div sequencer: FSM state encoding and
// operation / mux-select constants.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WBACK  = 3'd3,
        ST_DZERO  = 3'd4,
        ST_TOUT   = 3'd5
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // MuxHI/MuxLO select the result source with the same encoding as the op.
    localparam logic SEL_MULT = OP_MULT;
    localparam logic SEL_DIV  = OP_DIV;

endpackage : muldiv_sequencer_pkg

// File: rtl/muldiv_sequencer_wait_timer.sv
// Saturating wait counter with synchronous clear and a limit flag; shared by
// the mult/div sequencer and the control unit's memory-wait logic.
module muldiv_sequencer_wait_timer #(
    parameter int unsigned LIMIT = 40,
    parameter int unsigned CNT_W = 6
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic limit_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Holds at LAST so a stuck unit can never wrap the counter back to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !limit_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign limit_o = (count_q == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : muldiv_sequencer_wait_timer

// File: rtl/muldiv_sequencer.sv
// Launches the multiplier or divisor, waits for completion, then writes HI/LO
// or reports divide-by-zero / timeout. All outputs are Moore decodes.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned CNT_W          = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic op_valid,
    input  logic op_is_div,
    input  logic abort,
    input  logic mult_fim,
    input  logic div_fim,
    input  logic DividedByZero,
    output logic op_ready,
    output logic busy,
    output logic mult_start,
    output logic div_start,
    output logic HISelector,
    output logic LOSelector,
    output logic RegHIWrite,
    output logic RegLOWrite,
    output logic op_done,
    output logic div_zero_exc,
    output logic timeout_err
);

    state_e state_q, state_d;
    logic   opsel_q, opsel_d;
    logic   unit_done;
    logic   wait_limit;

    muldiv_sequencer_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .clk_i    (clock),
        .rst_ni   (reset),
        .clear_i  (state_q == ST_LAUNCH),
        .enable_i (state_q == ST_WAIT),
        .limit_o  (wait_limit)
    );

    // Only the launched unit's completion flag counts.
    assign unit_done = (opsel_q == OP_DIV) ? div_fim : mult_fim;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            opsel_q <= OP_MULT;
        end else begin
            state_q <= state_d;
            opsel_q <= opsel_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        opsel_d = opsel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    state_d = ST_LAUNCH;
                    opsel_d = op_is_div;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if ((opsel_q == OP_DIV) && DividedByZero) begin
                    state_d = ST_DZERO;
                end else if (unit_done) begin
                    state_d = ST_WBACK;
                end else if (wait_limit) begin
                    state_d = ST_TOUT;
                end
            end
            ST_WBACK, ST_DZERO, ST_TOUT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides every exit; this cycle's state-decoded pulses still fire.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        op_ready     = (state_q == ST_IDLE);
        busy         = (state_q != ST_IDLE);
        mult_start   = (state_q == ST_LAUNCH) && (opsel_q == OP_MULT);
        div_start    = (state_q == ST_LAUNCH) && (opsel_q == OP_DIV);
        HISelector   = opsel_q ? SEL_DIV : SEL_MULT;
        LOSelector   = opsel_q ? SEL_DIV : SEL_MULT;
        RegHIWrite   = (state_q == ST_WBACK);
        RegLOWrite   = (state_q == ST_WBACK);
        op_done      = (state_q == ST_WBACK);
        div_zero_exc = (state_q == ST_DZERO);
        timeout_err  = (state_q == ST_TOUT);
    end

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: one task per scenario, each with
// hand-computed latencies counted from the LAUNCH cycle.
module tb_muldiv_sequencer;

    localparam int NONE = -99;
    localparam int K_WBACK = 0;
    localparam int K_DZERO = 1;
    localparam int K_TOUT  = 2;
    localparam int K_ABORT = 3;

    logic clock = 1'b0;
    logic reset;
    logic op_valid, op_is_div, abort, mult_fim, div_fim, DividedByZero;
    logic op_ready, busy, mult_start, div_start, HISelector, LOSelector;
    logic RegHIWrite, RegLOWrite, op_done, div_zero_exc, timeout_err;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
        .clock         (clock),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_is_div     (op_is_div),
        .abort         (abort),
        .mult_fim      (mult_fim),
        .div_fim       (div_fim),
        .DividedByZero (DividedByZero),
        .op_ready      (op_ready),
        .busy          (busy),
        .mult_start    (mult_start),
        .div_start     (div_start),
        .HISelector    (HISelector),
        .LOSelector    (LOSelector),
        .RegHIWrite    (RegHIWrite),
        .RegLOWrite    (RegLOWrite),
        .op_done       (op_done),
        .div_zero_exc  (div_zero_exc),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        op_valid      = 1'b0;
        op_is_div     = 1'b0;
        abort         = 1'b0;
        mult_fim      = 1'b0;
        div_fim       = 1'b0;
        DividedByZero = 1'b0;
    endtask

    // Offset 0 is LAUNCH; WAIT cycle k (counter value k) sits at offset k+1.
    task automatic drive_events(input int o, input logic is_div, input int fim_k,
                                input int wrong_k, input int dz_k, input int abort_k);
        mult_fim      = (!is_div && o == fim_k + 1) || (is_div && o == wrong_k + 1);
        div_fim       = (is_div && o == fim_k + 1) || (!is_div && o == wrong_k + 1);
        DividedByZero = (o == dz_k + 1);
        abort         = (o == abort_k + 1);
    endtask

    task automatic run_op(input string name, input logic is_div, input int fim_k,
                          input int wrong_k, input int dz_k, input int abort_k,
                          input int kind, input int lat, input bit hold);
        logic [8:0] exp_v, got_v;
        int bad;
        op_valid  = 1'b1;
        op_is_div = is_div;
        tick();
        op_valid  = hold;
        op_is_div = hold ? ~is_div : is_div;
        checks++;
        if ({mult_start, div_start, busy, op_ready, HISelector, LOSelector} !==
            {~is_div, is_div, 1'b1, 1'b0, is_div, is_div}) begin
            errors++;
            $display("FAIL %s launch: got %b expected %b", name,
                     {mult_start, div_start, busy, op_ready, HISelector, LOSelector},
                     {~is_div, is_div, 1'b1, 1'b0, is_div, is_div});
        end
        drive_events(0, is_div, fim_k, wrong_k, dz_k, abort_k);
        tick();
        bad = 0;
        for (int o = 1; o < lat; o++) begin
            if ({mult_start, div_start, op_ready, RegHIWrite, RegLOWrite, op_done,
                 div_zero_exc, timeout_err} !== 8'd0 || busy !== 1'b1 ||
                HISelector !== is_div || LOSelector !== is_div) bad++;
            drive_events(o, is_div, fim_k, wrong_k, dz_k, abort_k);
            tick();
        end
        op_valid  = 1'b0;
        op_is_div = is_div;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s wait: %0d bad cycles, expected 0", name, bad);
        end
        // {HIw, LOw, done, dz, tout, ready, busy, HIsel, LOsel}
        case (kind)
            K_WBACK: exp_v = {7'b1110001, is_div, is_div};
            K_DZERO: exp_v = {7'b0001001, is_div, is_div};
            K_TOUT:  exp_v = {7'b0000101, is_div, is_div};
            default: exp_v = {7'b0000010, is_div, is_div};
        endcase
        got_v = {RegHIWrite, RegLOWrite, op_done, div_zero_exc, timeout_err,
                 op_ready, busy, HISelector, LOSelector};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s outcome: got %b expected %b", name, got_v, exp_v);
        end
        drive_events(lat, is_div, fim_k, wrong_k, dz_k, abort_k);
        tick();
        clear_inputs();
        got_v = {RegHIWrite, RegLOWrite, op_done, div_zero_exc, timeout_err,
                 op_ready, busy, mult_start, div_start};
        checks++;
        if (got_v !== 9'b000001000) begin
            errors++;
            $display("FAIL %s idle_after: got %b expected %b", name, got_v, 9'b000001000);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #12;
        checks++;
        if ({op_ready, busy, mult_start, div_start, HISelector, LOSelector, RegHIWrite,
             RegLOWrite, op_done, div_zero_exc, timeout_err} !== 11'b10000000000) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {op_ready, busy, mult_start, div_start, HISelector, LOSelector,
                      RegHIWrite, RegLOWrite, op_done, div_zero_exc, timeout_err},
                     11'b10000000000);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        run_op("mult_k33", 1'b0, 33, NONE, NONE, NONE, K_WBACK, 35, 1'b0);
    endtask

    task automatic test_div();
        run_op("div_k32", 1'b1, 32, NONE, NONE, NONE, K_WBACK, 34, 1'b0);
    endtask

    task automatic test_div_zero();
        run_op("dz_k2", 1'b1, NONE, NONE, 2, NONE, K_DZERO, 4, 1'b0);
        run_op("dz_and_fim", 1'b1, 10, NONE, 10, NONE, K_DZERO, 12, 1'b0);
    endtask

    task automatic test_timeout();
        run_op("timeout", 1'b0, NONE, NONE, NONE, NONE, K_TOUT, 41, 1'b0);
        run_op("fim_on_limit", 1'b0, 39, NONE, NONE, NONE, K_WBACK, 41, 1'b0);
        run_op("stale_launch_fim", 1'b0, -1, NONE, NONE, NONE, K_TOUT, 41, 1'b0);
    endtask

    task automatic test_abort_and_wrong_flag();
        int bad;
        run_op("abort_k5", 1'b0, NONE, NONE, NONE, 5, K_ABORT, 7, 1'b0);
        run_op("abort_in_wback", 1'b0, 4, NONE, NONE, 5, K_WBACK, 6, 1'b0);
        run_op("div_wrong_fim", 1'b1, 10, 3, NONE, NONE, K_WBACK, 12, 1'b0);
        run_op("mult_dz_ignored", 1'b0, 6, NONE, 2, NONE, K_WBACK, 8, 1'b0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            div_fim = 1'b1; mult_fim = 1'b1; DividedByZero = 1'b1; abort = 1'b1;
            tick();
            if ({op_ready, busy, mult_start, div_start, RegHIWrite, RegLOWrite, op_done,
                 div_zero_exc, timeout_err} !== 9'b100000000) bad++;
        end
        clear_inputs();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_stale_flags: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_busy_ignores_valid();
        run_op("valid_held_div", 1'b1, 5, NONE, NONE, NONE, K_WBACK, 7, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        op_valid  = 1'b1;
        op_is_div = 1'b1;
        tick();
        op_valid = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({op_ready, busy, mult_start, div_start, HISelector, LOSelector, RegHIWrite,
             RegLOWrite, op_done, div_zero_exc, timeout_err} !== 11'b10000000000) begin
            errors++;
            $display("FAIL reset_mid_op: got %b expected %b",
                     {op_ready, busy, mult_start, div_start, HISelector, LOSelector,
                      RegHIWrite, RegLOWrite, op_done, div_zero_exc, timeout_err},
                     11'b10000000000);
        end
        tick();
        reset = 1'b1;
        tick();
        run_op("mult_after_reset", 1'b0, 3, NONE, NONE, NONE, K_WBACK, 5, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_timeout();
        test_abort_and_wrong_flag();
        test_busy_ignores_valid();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_muldiv_sequencer
